rll16_key_loader: RTL and testbench

Serial key-delivery stage that sits directly upstream of the 16-bit random-logic-locked combinational benchmarks. It receives the unlock key bit-serially from the test/provisioning interface and checks a 4-bit nibble checksum. It commits the key onto a parallel bus that drives the locked netlist's key inputs, with `key_out[i]` driving `keyIn_0_i`. Repeated checksum failures lock the loader out until reset, so the key cannot be brute-forced through this port.

---
 rtl/rll16_key_loader_if.sv | 24 ++
 rtl/rll16_key_loader.sv | 147 ++++++++++++++
 tb/tb_rll16_key_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rll16_key_loader_if.sv
// Key-delivery bus between the provisioning port and the key loader.
// The master drives the serial frame; the slave (loader) returns the committed key and status.
interface rll16_key_loader_if #(
  parameter int KEY_W = 16
);
  logic             key_start;
  logic             bit_vld;
  logic             key_sdi;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             load_err;
  logic             lockout;

  modport master (
    output key_start, bit_vld, key_sdi,
    input  key_out, key_valid, busy, load_err, lockout
  );

  modport slave (
    input  key_start, bit_vld, key_sdi,
    output key_out, key_valid, busy, load_err, lockout
  );
endinterface

// File: rtl/rll16_key_loader.sv
// Serial key loader: shifts in a key plus a 4-bit nibble-XOR checksum, commits verified keys,
// and locks out after MAX_FAILS consecutive checksum failures.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no frame in progress, no valid key
// SHIFT_KEY | accepting KEY_W key bits, MSB first
// SHIFT_CHK | accepting 4 checksum bits, MSB first
// CHECK     | one cycle: compare checksum, commit key or flag error
// LOADED    | key_out holds a verified key
// LOCKOUT   | too many failures; absorbing until reset
module rll16_key_loader #(
  parameter int KEY_W     = 16,
  parameter int MAX_FAILS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  rll16_key_loader_if.slave bus
);

  localparam int CNT_W = $clog2(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_KEY,
    S_SHIFT_CHK,
    S_CHECK,
    S_LOADED,
    S_LOCKOUT
  } state_t;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] shreg;
  logic [3:0]       chk_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       fail_cnt;
  logic [3:0]       fail_inc;
  logic [3:0]       chk_calc;
  logic             last_key, last_chk;
  logic             start_acc, shift_key, shift_chk, commit, fail;
  logic             busy_nxt;

  always_comb begin
    chk_calc = 4'd0;
    for (int i = 0; i < KEY_W / 4; i++) begin
      chk_calc = chk_calc ^ shreg[4*i +: 4];
    end
  end

  assign last_key = (bit_cnt == CNT_W'(KEY_W - 1));
  assign last_chk = (bit_cnt == CNT_W'(3));
  assign fail_inc = fail_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    shift_key = 1'b0;
    shift_chk = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    case (state)
      S_IDLE, S_LOADED: begin
        if (bus.key_start) begin
          start_acc = 1'b1;
          state_nxt = S_SHIFT_KEY;
        end
      end
      S_SHIFT_KEY: begin
        // a restart takes priority over a coincident data bit
        if (bus.key_start) begin
          start_acc = 1'b1;
        end else if (bus.bit_vld) begin
          shift_key = 1'b1;
          if (last_key) state_nxt = S_SHIFT_CHK;
        end
      end
      S_SHIFT_CHK: begin
        if (bus.key_start) begin
          start_acc = 1'b1;
          state_nxt = S_SHIFT_KEY;
        end else if (bus.bit_vld) begin
          shift_chk = 1'b1;
          if (last_chk) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (chk_calc == chk_sr) begin
          commit    = 1'b1;
          state_nxt = S_LOADED;
        end else begin
          fail      = 1'b1;
          state_nxt = (fail_inc == 4'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_LOCKOUT: state_nxt = S_LOCKOUT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == S_SHIFT_KEY) || (state_nxt == S_SHIFT_CHK) ||
                    (state_nxt == S_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      shreg         <= '0;
      chk_sr        <= 4'd0;
      bit_cnt       <= '0;
      fail_cnt      <= 4'd0;
      bus.key_out   <= '0;
      bus.key_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.load_err  <= 1'b0;
      bus.lockout   <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.busy     <= busy_nxt;
      bus.lockout  <= (state_nxt == S_LOCKOUT);
      bus.load_err <= fail;
      if (start_acc) begin
        shreg         <= '0;
        chk_sr        <= 4'd0;
        bit_cnt       <= '0;
        bus.key_out   <= '0;
        bus.key_valid <= 1'b0;
      end else if (shift_key) begin
        shreg   <= {shreg[KEY_W-2:0], bus.key_sdi};
        bit_cnt <= last_key ? '0 : bit_cnt + CNT_W'(1);
      end else if (shift_chk) begin
        chk_sr  <= {chk_sr[2:0], bus.key_sdi};
        bit_cnt <= last_chk ? '0 : bit_cnt + CNT_W'(1);
      end else if (commit) begin
        bus.key_out   <= shreg;
        bus.key_valid <= 1'b1;
        fail_cnt      <= 4'd0;
      end else if (fail) begin
        // failed material is scrubbed so nothing partial survives into IDLE/LOCKOUT
        fail_cnt      <= fail_inc;
        shreg         <= '0;
        chk_sr        <= 4'd0;
        bus.key_out   <= '0;
        bus.key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rll16_key_loader.sv
// Scoreboard bench for rll16_key_loader: frames push expected outcomes, a monitor pops
// and compares whenever the loader commits a key or flags a checksum error.
module tb_rll16_key_loader;

  localparam int KEY_W     = 16;
  localparam int MAX_FAILS = 3;

  typedef struct {
    logic             err;
    logic [KEY_W-1:0] key;
    logic             lock;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   busy_cnt;
  int   fails_m;
  logic locked_m;
  logic kv_prev;
  logic le_prev;
  exp_t exp_q[$];

  rll16_key_loader_if #(.KEY_W(KEY_W)) ifc ();

  rll16_key_loader #(.KEY_W(KEY_W), .MAX_FAILS(MAX_FAILS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.busy) busy_cnt++;
  end

  // monitor: any load_err pulse or key_valid rise must match the next queued expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      kv_prev = 1'b0;
      le_prev = 1'b0;
    end else begin
      if (ifc.load_err && le_prev) check("load_err_width", 32'd2, 32'd1);
      if (ifc.load_err || (ifc.key_valid && !kv_prev)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {ifc.load_err, ifc.key_valid, ifc.key_out}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("load_err", 32'(ifc.load_err), 32'(e.err));
          check("key_out", 32'(ifc.key_out), 32'(e.key));
          check("key_valid", 32'(ifc.key_valid), 32'(!e.err));
          check("lockout", 32'(ifc.lockout), 32'(e.lock));
        end
      end
      kv_prev = ifc.key_valid;
      le_prev = ifc.load_err;
    end
  end

  task automatic drive(input logic s, input logic v, input logic d);
    @(negedge clk);
    ifc.key_start = s;
    ifc.bit_vld   = v;
    ifc.key_sdi   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps) idle($urandom_range(0, 3));
  endtask

  // full frame; good is the hand-computed verdict of the checksum
  task automatic send_frame(input logic [KEY_W-1:0] key, input logic [3:0] chk,
                            input bit good, input bit gaps, input logic start_bit);
    if (!locked_m) begin
      exp_t e;
      if (good) begin
        e.err = 1'b0; e.key = key; e.lock = 1'b0;
        fails_m = 0;
      end else begin
        fails_m++;
        locked_m = (fails_m == MAX_FAILS);
        e.err = 1'b1; e.key = '0; e.lock = locked_m;
      end
      exp_q.push_back(e);
    end
    drive(1'b1, start_bit, 1'b1);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      maybe_gap(gaps);
      drive(1'b0, 1'b1, key[i]);
    end
    for (int i = 3; i >= 0; i--) begin
      maybe_gap(gaps);
      drive(1'b0, 1'b1, chk[i]);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    ifc.key_start = 1'b0;
    ifc.bit_vld   = 1'b0;
    #1;
    check("rst_key_out", 32'(ifc.key_out), 32'd0);
    check("rst_key_valid", 32'(ifc.key_valid), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_load_err", 32'(ifc.load_err), 32'd0);
    check("rst_lockout", 32'(ifc.lockout), 32'd0);
    fails_m  = 0;
    locked_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    busy_cnt      = 0;
    fails_m       = 0;
    locked_m      = 1'b0;
    rst_n         = 1'b0;
    ifc.key_start = 1'b0;
    ifc.bit_vld   = 1'b0;
    ifc.key_sdi   = 1'b0;
    #2;
    check("init_key_out", 32'(ifc.key_out), 32'd0);
    check("init_key_valid", 32'(ifc.key_valid), 32'd0);
    check("init_busy", 32'(ifc.busy), 32'd0);
    check("init_lockout", 32'(ifc.lockout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // good frame back-to-back, latency and busy width
    busy_cnt = 0;
    send_frame(16'h1234, 4'h4, 1'b1, 1'b0, 1'b0);
    check("latency_not_early", 32'(ifc.key_valid), 32'd0);
    idle(1);
    check("latency_valid", 32'(ifc.key_valid), 32'd1);
    check("latency_key", 32'(ifc.key_out), 32'h1234);
    idle(2);
    check("busy_cycles", 32'(busy_cnt), 32'd21);
    do_reset();
    idle(1);

    // single bad frame returns to idle with nothing committed
    send_frame(16'h1234, 4'h5, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("bad_busy", 32'(ifc.busy), 32'd0);
    check("bad_key_out", 32'(ifc.key_out), 32'd0);
    check("bad_lockout", 32'(ifc.lockout), 32'd0);

    // two more failures reach lockout; a good frame is then ignored
    send_frame(16'h1234, 4'h0, 1'b0, 1'b0, 1'b0);
    send_frame(16'hBEEF, 4'h6, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("lock_set", 32'(ifc.lockout), 32'd1);
    send_frame(16'hA5C3, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("lock_key_out", 32'(ifc.key_out), 32'd0);
    check("lock_key_valid", 32'(ifc.key_valid), 32'd0);
    check("lock_busy", 32'(ifc.busy), 32'd0);
    check("lock_held", 32'(ifc.lockout), 32'd1);
    do_reset();
    idle(1);

    // a good load clears the consecutive-failure count
    send_frame(16'h0001, 4'h0, 1'b0, 1'b1, 1'b0);
    send_frame(16'hA5C3, 4'h1, 1'b0, 1'b0, 1'b0);
    send_frame(16'hA5C3, 4'h0, 1'b1, 1'b1, 1'b0);
    send_frame(16'hFFFF, 4'hF, 1'b0, 1'b0, 1'b0);
    send_frame(16'h8000, 4'h0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("no_lock_after_clear", 32'(ifc.lockout), 32'd0);

    // abort after 9 bits with a coincident bit, then full frame
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'(i % 2));
    send_frame(16'hBEEF, 4'h4, 1'b1, 1'b1, 1'b1);
    idle(2);
    check("abort_key_out", 32'(ifc.key_out), 32'hBEEF);
    check("abort_lockout", 32'(ifc.lockout), 32'd0);

    // load with gaps, then reset in the middle of the next frame
    send_frame(16'h1234, 4'h4, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("gap_key_out", 32'(ifc.key_out), 32'h1234);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1);
    check("midframe_busy", 32'(ifc.busy), 32'd1);
    do_reset();
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_key_valid", 32'(ifc.key_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
